// File: rtl/i2s_mic_sim_gen.sv
`default_nettype none
// ============================================================================
// Module   : i2s_mic_sim_gen
// Brief    : Parametrised Philips-I2S microphone model (LFSR/ramp/const/square)
//            with a sample monitor port. Define I2S_SIM_STEREO_EN for stereo.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_mic_sim_gen #(
    parameter int                    SAMPLE_BITS = 24,
    parameter int                    SLOT_BITS   = 32,
    parameter int                    LFSR_WIDTH  = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED   = {{(LFSR_WIDTH-1){1'b0}}, 1'b1},
    parameter logic                  CHANNEL_SEL = 1'b0
) (
    input  logic                   SCK,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [SAMPLE_BITS-1:0] const_value,
    output logic                   WS,
    output logic                   SD,
    output logic                   sample_strobe,
    output logic [SAMPLE_BITS-1:0] sample_out,
    output logic                   sample_ch
);

    localparam int                 c_OFF_W    = $clog2(SLOT_BITS);
    localparam logic [c_OFF_W-1:0] c_OFF_LAST = c_OFF_W'(SLOT_BITS - 1);
    localparam logic [c_OFF_W-1:0] c_OFF_LSB  = c_OFF_W'(SAMPLE_BITS);
    localparam logic [31:0]        c_TAPS     = (LFSR_WIDTH == 8)  ? 32'h0000_00B8 :
                                                (LFSR_WIDTH == 16) ? 32'h0000_D008 :
                                                (LFSR_WIDTH == 24) ? 32'h00E1_0000 :
                                                                     32'h8020_0003;
    localparam logic [SAMPLE_BITS-1:0] c_SQ_POS = {1'b0, {(SAMPLE_BITS-1){1'b1}}};
    localparam logic [SAMPLE_BITS-1:0] c_SQ_NEG = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

    logic [c_OFF_W-1:0]     off_q, off_d;
    logic                   ws_q, ws_d;
    logic                   sd_q, sd_d;
    logic                   strobe_q, strobe_d;
    logic                   ch_q, ch_d;
    logic [SAMPLE_BITS-1:0] sample_q, sample_d;
    logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
    logic [LFSR_WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [SAMPLE_BITS-1:0] ramp_q, ramp_d;
    logic                   sq_neg_q, sq_neg_d;

    logic                   w_wrap;
    logic [c_OFF_W-1:0]     w_off_next;
    logic                   w_ws_next;
    logic                   w_slot_active;
    logic                   w_lfsr_fb;
    logic [SAMPLE_BITS-1:0] w_lfsr_word;
    logic [SAMPLE_BITS-1:0] w_src;

    assign w_wrap     = (off_q == c_OFF_LAST);
    assign w_off_next = w_wrap ? '0 : off_q + 1'b1;
    assign w_ws_next  = ws_q ^ w_wrap;

`ifdef I2S_SIM_STEREO_EN
    assign w_slot_active = 1'b1;
`else
    assign w_slot_active = (w_ws_next == CHANNEL_SEL);
`endif

    assign w_lfsr_fb = ^(lfsr_q & c_TAPS[LFSR_WIDTH-1:0]);

    // LFSR value sits in the top bits of the sample, low bits zero
    always_comb begin
        w_lfsr_word = '0;
        w_lfsr_word[SAMPLE_BITS-1 -: LFSR_WIDTH] = lfsr_q;
        case (mode)
            2'd0:    w_src = w_lfsr_word;
            2'd1:    w_src = ramp_q;
            2'd2:    w_src = const_value;
            default: w_src = sq_neg_q ? c_SQ_NEG : c_SQ_POS;
        endcase
    end

    always_comb begin
        off_d    = off_q;
        ws_d     = ws_q;
        sd_d     = 1'b0;
        strobe_d = 1'b0;
        ch_d     = ch_q;
        sample_d = sample_q;
        shreg_d  = shreg_q;
        lfsr_d   = lfsr_q;
        ramp_d   = ramp_q;
        sq_neg_d = sq_neg_q;
        if (enable) begin
            off_d = w_off_next;
            ws_d  = w_ws_next;
            if (w_slot_active) begin
                if (w_off_next == '0) begin
                    // Word is latched before the generators step forward
                    shreg_d  = w_src;
                    sample_d = w_src;
                    ch_d     = w_ws_next;
                    strobe_d = 1'b1;
                    lfsr_d   = {lfsr_q[LFSR_WIDTH-2:0], w_lfsr_fb};
                    ramp_d   = ramp_q + 1'b1;
                    sq_neg_d = ~sq_neg_q;
                end else if (w_off_next <= c_OFF_LSB) begin
                    sd_d    = shreg_q[SAMPLE_BITS-1];
                    shreg_d = shreg_q << 1;
                end
            end
        end
    end

    always_ff @(posedge SCK) begin
        if (!reset_n) begin
            off_q    <= c_OFF_LAST;
            ws_q     <= 1'b1;
            sd_q     <= 1'b0;
            strobe_q <= 1'b0;
            ch_q     <= 1'b0;
            sample_q <= '0;
            shreg_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            ramp_q   <= '0;
            sq_neg_q <= 1'b0;
        end else begin
            off_q    <= off_d;
            ws_q     <= ws_d;
            sd_q     <= sd_d;
            strobe_q <= strobe_d;
            ch_q     <= ch_d;
            sample_q <= sample_d;
            shreg_q  <= shreg_d;
            lfsr_q   <= lfsr_d;
            ramp_q   <= ramp_d;
            sq_neg_q <= sq_neg_d;
        end
    end

    assign WS            = ws_q;
    assign SD            = sd_q;
    assign sample_strobe = strobe_q;
    assign sample_out    = sample_q;
    assign sample_ch     = ch_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_mic_sim_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_mic_sim_gen
// Brief    : Randomised bench for i2s_mic_sim_gen (left and right mono slot
//            instances, or two stereo instances) against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_mic_sim_gen;

    localparam int SB   = 24;
    localparam int SLOT = 32;
    localparam int LW   = 16;
`ifdef I2S_SIM_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif
    localparam logic [31:0] SMASK  = (32'h1 << SB) - 32'h1;
    localparam logic [31:0] SQ_POS = (32'h1 << (SB - 1)) - 32'h1;
    localparam logic [31:0] SQ_NEG = 32'h1 << (SB - 1);

    logic          SCK;
    logic          reset_n;
    logic          enable;
    logic [1:0]    mode;
    logic [SB-1:0] const_value;
    logic [1:0]    ws, sd, stb, ch;
    logic [SB-1:0] so [2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, one entry per instance (index = CHANNEL_SEL)
    int          m_pos   [2];
    logic [31:0] m_lfsr  [2];
    logic [31:0] m_ramp  [2];
    bit          m_sqneg [2];
    logic [31:0] m_word  [2];
    logic [31:0] m_out   [2];
    bit          m_ch    [2];
    bit          m_stb   [2];
    bit          m_sd    [2];

    i2s_mic_sim_gen #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .LFSR_WIDTH(LW),
                      .LFSR_SEED(16'h0001), .CHANNEL_SEL(1'b0)) u_dut0 (
        .SCK(SCK), .reset_n(reset_n), .enable(enable), .mode(mode),
        .const_value(const_value), .WS(ws[0]), .SD(sd[0]),
        .sample_strobe(stb[0]), .sample_out(so[0]), .sample_ch(ch[0]));

    i2s_mic_sim_gen #(.SAMPLE_BITS(SB), .SLOT_BITS(SLOT), .LFSR_WIDTH(LW),
                      .LFSR_SEED(16'h0001), .CHANNEL_SEL(1'b1)) u_dut1 (
        .SCK(SCK), .reset_n(reset_n), .enable(enable), .mode(mode),
        .const_value(const_value), .WS(ws[1]), .SD(sd[1]),
        .sample_strobe(stb[1]), .sample_out(so[1]), .sample_ch(ch[1]));

    initial SCK = 1'b0;
    always #5 SCK = ~SCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        int          t [4];
        logic [63:0] one;
        logic        fb;
        case (LW)
            8:       t = '{8, 6, 5, 4};
            16:      t = '{16, 15, 13, 4};
            24:      t = '{24, 23, 22, 17};
            default: t = '{32, 22, 2, 1};
        endcase
        fb  = v[t[0]-1] ^ v[t[1]-1] ^ v[t[2]-1] ^ v[t[3]-1];
        one = 64'h1;
        return 32'(((64'(v) << 1) | 64'(fb)) & ((one << LW) - 64'h1));
    endfunction

    task automatic model_step(input int d);
        int          o, slot;
        bit          act;
        logic [31:0] src;
        m_stb[d] = 1'b0;
        m_sd[d]  = 1'b0;
        if (!reset_n) begin
            m_pos[d]   = 2 * SLOT - 1;
            m_lfsr[d]  = 32'h1;
            m_ramp[d]  = 32'h0;
            m_sqneg[d] = 1'b0;
            m_word[d]  = 32'h0;
            m_out[d]   = 32'h0;
            m_ch[d]    = 1'b0;
        end else if (enable) begin
            m_pos[d] = (m_pos[d] + 1) % (2 * SLOT);
            o    = m_pos[d] % SLOT;
            slot = m_pos[d] / SLOT;
            act  = STEREO || (slot == d);
            if (act && o == 0) begin
                case (mode)
                    2'd0:    src = (m_lfsr[d] << (SB - LW)) & SMASK;
                    2'd1:    src = m_ramp[d];
                    2'd2:    src = 32'(const_value);
                    default: src = m_sqneg[d] ? SQ_NEG : SQ_POS;
                endcase
                m_word[d]  = src;
                m_out[d]   = src;
                m_ch[d]    = (slot == 1);
                m_stb[d]   = 1'b1;
                m_lfsr[d]  = lfsr_next(m_lfsr[d]);
                m_ramp[d]  = (m_ramp[d] + 32'h1) & SMASK;
                m_sqneg[d] = !m_sqneg[d];
            end else if (act && o <= SB) begin
                m_sd[d] = m_word[d][SB - o];
            end
        end
    endtask

    task automatic tick();
        @(posedge SCK);
        for (int d = 0; d < 2; d++) model_step(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("WS%0d", d),     32'(ws[d]),  32'(m_pos[d] >= SLOT));
            check($sformatf("SD%0d", d),     32'(sd[d]),  32'(m_sd[d]));
            check($sformatf("STB%0d", d),    32'(stb[d]), 32'(m_stb[d]));
            check($sformatf("SAMPLE%0d", d), 32'(so[d]),  m_out[d]);
            check($sformatf("CH%0d", d),     32'(ch[d]),  32'(m_ch[d]));
        end
    endtask

    initial begin
        logic [31:0] lfsr_exp [5];
        int          n_cap;
        int          burst;
        lfsr_exp = '{32'h000100, 32'h000200, 32'h000400, 32'h000800, 32'h001100};

        reset_n     = 1'b0;
        enable      = 1'b1;
        mode        = 2'd0;
        const_value = 24'hA5A5A5;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_ws", 32'(ws[0]), 32'h1);
            check("rst_sd", 32'(sd[0]), 32'h0);
            check("rst_stb", 32'(stb[0]), 32'h0);
            check("rst_sample", 32'(so[0]), 32'h0);
        end

        // Seed-derived LFSR sequence on the left-slot instance
        reset_n = 1'b1;
        n_cap   = 0;
        tick();
        check("first_ws_fall", 32'(ws[0]), 32'h0);
        check("first_strobe", 32'(stb[0]), 32'h1);
        if (stb[0]) begin
            check("lfsr_seq", 32'(so[0]), lfsr_exp[0]);
            n_cap++;
        end
        for (int i = 0; i < 5 * 2 * SLOT; i++) begin
            tick();
            if (stb[0] && n_cap < 5) begin
                check("lfsr_seq", 32'(so[0]), lfsr_exp[n_cap]);
                n_cap++;
            end
        end
        check("lfsr_count", 32'(n_cap), 32'd5);

        // Ramp after a fresh reset
        reset_n = 1'b0;
        mode    = 2'd1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4 * 2 * SLOT; i++) tick();

        // Mid-slot mode switch square -> constant
        mode = 2'd3;
        while (m_pos[0] != 10) tick();
        mode = 2'd2;
        for (int i = 0; i < 2 * 2 * SLOT; i++) tick();

        // Randomised operation with pauses, mode changes and mid-frame resets
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 599) != 0);
            if (burst > 0) begin
                enable = 1'b0;
                burst--;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 24) == 0) burst = $urandom_range(1, 10);
            end
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) const_value = SB'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
